// File: rtl/ysyx_23060096_sram.sv
// Word-organised data memory with valid/ready request/response channels and a fixed access latency.
// Define YSYX_23060096_SRAM_RAND_DELAY_EN to add an LFSR-driven random extra delay per access.
module ysyx_23060096_sram #(
    parameter int AW      = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_memop,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [3:0]  w_load_cnt;
    logic        w_accept;
    logic        w_exec;

    logic        r_wen;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [2:0]  r_memop;

    logic        w_a_wen;
    logic [31:0] w_a_addr;
    logic [31:0] w_a_wdata;
    logic [2:0]  w_a_memop;
    logic [AW-1:0] w_idx;
    logic [1:0]  w_lane;
    logic        w_err;
    logic        w_we;
    logic [31:0] w_rword;

    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    logic [31:0] r_mem [0:(2**AW)-1];

    function automatic logic [31:0] f_load_ext(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  memop);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (memop)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b010:  return sh;
            3'b100:  return {24'd0, sh[7:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] f_store_merge(input logic [31:0] old,
                                                  input logic [31:0] wdata,
                                                  input logic [1:0]  lane,
                                                  input logic [1:0]  size);
        logic [3:0]  be;
        logic [31:0] sh;
        logic [31:0] res;
        case (size)
            2'b00:   be = 4'b0001 << lane;
            2'b01:   be = 4'b0011 << lane;
            default: be = 4'b1111;
        endcase
        sh = wdata << {lane, 3'b000};
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? sh[8*b +: 8] : old[8*b +: 8];
        end
        return res;
    endfunction

`ifdef YSYX_23060096_SRAM_RAND_DELAY_EN
    logic [7:0] r_lfsr;
    logic [4:0] w_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 8'hA5;
        end else begin
            r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
        end
    end

    always_comb begin
        w_sum      = 5'(LATENCY) + {2'b00, r_lfsr[2:0]};
        w_load_cnt = (w_sum > 5'd15) ? 4'd15 : w_sum[3:0];
    end
`else
    assign w_load_cnt = 4'(LATENCY);
`endif

    // With zero latency the access runs on the acceptance edge, so it uses the live request.
    assign w_a_wen   = (r_state == S_IDLE) ? req_wen   : r_wen;
    assign w_a_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_a_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
    assign w_a_memop = (r_state == S_IDLE) ? req_memop : r_memop;
    assign w_idx     = w_a_addr[AW+1:2];
    assign w_lane    = w_a_addr[1:0];
    assign w_rword   = r_mem[w_idx];

    always_comb begin
        w_err = 1'b0;
        if (w_a_memop[1:0] == 2'b11 || (w_a_memop[2] && w_a_memop[1]) || (w_a_wen && w_a_memop[2]))
            w_err = 1'b1;
        if (w_a_memop[1:0] == 2'b01 && w_lane[0])
            w_err = 1'b1;
        if (w_a_memop[1:0] == 2'b10 && w_lane != 2'b00)
            w_err = 1'b1;
        if ((w_a_addr >> (AW + 2)) != 32'd0)
            w_err = 1'b1;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_exec   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (req_valid && !rst) begin
                    w_accept = 1'b1;
                    w_exec   = (w_load_cnt == 4'd0);
                    w_next   = (w_load_cnt == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_exec = !rst;
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_we = w_exec && w_a_wen && !w_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept)
                r_cnt <= w_load_cnt;
            else if (r_state == S_WAIT)
                r_cnt <= r_cnt - 4'd1;
            if (w_exec) begin
                r_resp_rdata <= (w_err || w_a_wen) ? 32'd0 : f_load_ext(w_rword, w_lane, w_a_memop);
                r_resp_err   <= w_err;
            end else if (r_state == S_RESP && resp_ready) begin
                r_resp_rdata <= 32'd0;
                r_resp_err   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_wen   <= req_wen;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_memop <= req_memop;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_idx] <= f_store_merge(w_rword, w_a_wdata, w_lane, w_a_memop[1:0]);
    end

    assign req_ready  = (r_state == S_IDLE) && !rst;
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_ysyx_23060096_sram.sv
// Bench for ysyx_23060096_sram: directed vector table, backpressure/reset sequences, random traffic vs a byte-level model.
module tb_ysyx_23060096_sram;

    localparam int AW = 10;
    localparam int L  = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_memop;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mdl [0:15];

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  op;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    ysyx_23060096_sram #(.AW(AW), .LATENCY(L)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_memop  (req_memop),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic chk_lat(input string name, input int lat);
`ifdef YSYX_23060096_SRAM_RAND_DELAY_EN
        n_checks++;
        if (lat >= L + 1 && lat <= L + 8 && lat <= 16) n_pass++;
        else $display("FAIL %s: latency %0d, expected %0d..%0d", name, lat, L + 1, L + 8);
`else
        chk(name, lat, L + 1);
`endif
    endtask

    // Reference: plain byte-by-byte arithmetic over a 16-word region.
    function automatic void mdl_access(input logic wen, input logic [31:0] addr,
                                       input logic [31:0] wdata, input logic [2:0] op,
                                       output logic [31:0] rd, output logic er);
        int size;
        bit sgn;
        int wi;
        int lane;
        rd = 0; er = 0; size = 4; sgn = 0;
        case (op)
            3'd0: begin size = 1; sgn = 1; end
            3'd1: begin size = 2; sgn = 1; end
            3'd2: begin size = 4; sgn = 0; end
            3'd4: begin size = 1; sgn = 0; end
            3'd5: begin size = 2; sgn = 0; end
            default: er = 1;
        endcase
        if (wen && op >= 3'd4) er = 1;
        if (addr % size != 0) er = 1;
        if (addr >= 32'(4 * (2 ** AW))) er = 1;
        if (er) return;
        wi = int'(addr / 4) % 16;
        lane = int'(addr % 4);
        for (int i = 0; i < size; i++) begin
            if (wen) mdl[wi][8*(lane+i) +: 8] = wdata[8*i +: 8];
            else     rd[8*i +: 8] = mdl[wi][8*(lane+i) +: 8];
        end
        if (!wen && sgn && rd[8*size-1])
            for (int j = size; j < 4; j++) rd[8*j +: 8] = 8'hFF;
    endfunction

    task automatic do_req(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [2:0] op, output logic [31:0] rd, output logic er,
                          output int lat);
        lat = -1; rd = 0; er = 0;
        @(negedge clk);
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_memop = op;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = n; rd = resp_rdata; er = resp_err;
                break;
            end
        end
        if (lat > 0) @(posedge clk);
    endtask

    initial begin
        logic [31:0] rd, exp_rd;
        logic        er, exp_er;
        int          lat;
        bit          seen;

        rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_addr = 0; req_wdata = 0;
        req_memop = 0; resp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err", resp_err, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_req_ready", req_ready, 1);

        for (int i = 0; i < 16; i++) begin
            do_req(1'b1, 32'(4 * i), 32'd0, 3'b010, rd, er, lat);
            mdl[i] = 32'd0;
        end
        chk("init_store_err", er, 0);

        vecs.push_back(vec_t'{1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0,        1'b0});
        vecs.push_back(vec_t'{1'b0, 32'h10, 32'h0,        3'b010, 32'hDEADBEEF, 1'b0});
        vecs.push_back(vec_t'{1'b1, 32'h13, 32'h80,       3'b000, 32'h0,        1'b0});
        vecs.push_back(vec_t'{1'b0, 32'h13, 32'h0,        3'b000, 32'hFFFFFF80, 1'b0});
        vecs.push_back(vec_t'{1'b0, 32'h13, 32'h0,        3'b100, 32'h00000080, 1'b0});
        vecs.push_back(vec_t'{1'b0, 32'h10, 32'h0,        3'b010, 32'h80ADBEEF, 1'b0});
        vecs.push_back(vec_t'{1'b1, 32'h16, 32'hA5A5,     3'b001, 32'h0,        1'b0});
        vecs.push_back(vec_t'{1'b0, 32'h16, 32'h0,        3'b101, 32'h0000A5A5, 1'b0});
        vecs.push_back(vec_t'{1'b0, 32'h16, 32'h0,        3'b001, 32'hFFFFA5A5, 1'b0});
        vecs.push_back(vec_t'{1'b0, 32'h14, 32'h0,        3'b010, 32'hA5A50000, 1'b0});
        vecs.push_back(vec_t'{1'b0, 32'h02, 32'h0,        3'b010, 32'h0,        1'b1});
        vecs.push_back(vec_t'{1'b1, 32'h01, 32'hFFFF,     3'b001, 32'h0,        1'b1});
        vecs.push_back(vec_t'{1'b0, 32'h00, 32'h0,        3'b010, 32'h0,        1'b0});
        vecs.push_back(vec_t'{1'b0, 32'h1000, 32'h0,      3'b010, 32'h0,        1'b1});
        vecs.push_back(vec_t'{1'b0, 32'h00, 32'h0,        3'b011, 32'h0,        1'b1});
        vecs.push_back(vec_t'{1'b1, 32'h12, 32'h12345678, 3'b010, 32'h0,        1'b1});
        vecs.push_back(vec_t'{1'b0, 32'h10, 32'h0,        3'b010, 32'h80ADBEEF, 1'b0});

        foreach (vecs[k]) begin
            do_req(vecs[k].wen, vecs[k].addr, vecs[k].wdata, vecs[k].op, rd, er, lat);
            mdl_access(vecs[k].wen, vecs[k].addr, vecs[k].wdata, vecs[k].op, exp_rd, exp_er);
            chk($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rd);
            chk($sformatf("vec%0d_err", k), er, vecs[k].exp_err);
            chk_lat($sformatf("vec%0d_lat", k), lat);
        end

        // Backpressure: response must hold while resp_ready is low.
        resp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h10; req_memop = 3'b010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            seen = resp_valid;
        end
        chk("bp_resp_seen", seen, 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid_hold", resp_valid, 1);
            chk("bp_rdata_hold", resp_rdata, 32'h80ADBEEF);
            chk("bp_err_hold", resp_err, 0);
            chk("bp_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", resp_valid, 0);
        chk("bp_release_ready", req_ready, 1);

        // Reset during WAIT abandons the store.
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h10; req_wdata = 32'h12345678;
        req_memop = 3'b010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_resp_valid", resp_valid, 0);
        chk("rstw_req_ready", req_ready, 0);
        rst = 1'b0;
        seen = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        chk("rstw_no_resp", seen, 0);
        do_req(1'b0, 32'h10, 32'h0, 3'b010, rd, er, lat);
        chk("rstw_lw_rdata", rd, 32'h80ADBEEF);
        chk("rstw_lw_err", er, 0);

        // Random traffic against the model.
        for (int t = 0; t < 200; t++) begin
            logic        wen;
            logic [31:0] addr;
            logic [31:0] wdata;
            logic [2:0]  op;
            wen = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) addr = 32'h1000 + 32'($urandom_range(0, 4095));
            else                           addr = 32'($urandom_range(0, 63));
            wdata = $urandom;
            op = 3'($urandom_range(0, 7));
            if (wen && (op == 3'd4 || op == 3'd5)) op = 3'd2;
            mdl_access(wen, addr, wdata, op, exp_rd, exp_er);
            do_req(wen, addr, wdata, op, rd, er, lat);
            chk($sformatf("rnd%0d_rdata", t), rd, exp_rd);
            chk($sformatf("rnd%0d_err", t), er, exp_er);
            chk_lat($sformatf("rnd%0d_lat", t), lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
